riscv_ras_ctrl: RTL

Return-address-stack controller for the RISC-V core's memory-unit PC path. It tracks call/return events on accepted instructions and maintains a circular stack of return addresses. It produces the registered ras_read strobe and predicted return PC that feed the MU PC skid buffer. It also handles overflow, underflow and pipeline flush.

---
 rtl/riscv_ras_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/riscv_ras_ctrl.sv
// Return-address-stack controller: circular stack of return PCs with registered pop strobe.
// Optional RISCV_RAS_CHECKPOINT_EN adds a {tos,count} checkpoint restored on flush.
module riscv_ras_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 8,
   parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  i_stall,
   input  logic                  i_valid,
   input  logic                  i_call,
   input  logic                  i_ret,
   input  logic [DATA_WIDTH-1:0] i_pc,
   input  logic                  i_flush,
`ifdef RISCV_RAS_CHECKPOINT_EN
   input  logic                  i_ckpt_save,
`endif
   output logic                  o_ras_read,
   output logic [DATA_WIDTH-1:0] o_ret_pc,
   output logic                  o_empty,
   output logic                  o_full,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam logic [PTR_WIDTH:0] CNT_FULL = (PTR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_WIDTH-1:0]  r_tos;
   logic [PTR_WIDTH:0]    r_cnt;
   logic [DATA_WIDTH-1:0] r_ret_pc;
   logic                  r_ras_read;
   logic                  r_ovf;
   logic                  r_unf;

   logic                  w_upd;
   logic                  w_empty;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_push_val;
   logic [PTR_WIDTH-1:0]  w_tos_inc;
   logic [PTR_WIDTH-1:0]  w_tos_dec;
   logic [PTR_WIDTH-1:0]  w_tos_nxt;
   logic [PTR_WIDTH:0]    w_cnt_nxt;
   logic                  w_wr_en;
   logic [PTR_WIDTH-1:0]  w_wr_idx;
   logic                  w_pop;
   logic                  w_ovf;
   logic                  w_unf;
   logic [PTR_WIDTH-1:0]  w_flush_tos;
   logic [PTR_WIDTH:0]    w_flush_cnt;

   assign w_upd      = enable && i_valid && !i_stall;
   assign w_empty    = (r_cnt == '0);
   assign w_full     = (r_cnt == CNT_FULL);
   assign w_push_val = i_pc + DATA_WIDTH'(4);
   assign w_tos_inc  = r_tos + PTR_WIDTH'(1);
   assign w_tos_dec  = r_tos - PTR_WIDTH'(1);

   // Next-state decode for one accepted instruction; a pop always reads the pre-update top.
   always_comb begin
      w_tos_nxt = r_tos;
      w_cnt_nxt = r_cnt;
      w_wr_en   = 1'b0;
      w_wr_idx  = r_tos;
      w_pop     = 1'b0;
      w_ovf     = 1'b0;
      w_unf     = 1'b0;
      if (w_upd) begin
         if (i_call && i_ret) begin
            w_wr_en = 1'b1;
            if (w_empty) begin
               w_cnt_nxt = (PTR_WIDTH+1)'(1);
               w_unf     = 1'b1;
            end else begin
               w_pop = 1'b1;
            end
         end else if (i_call) begin
            w_tos_nxt = w_tos_inc;
            w_wr_en   = 1'b1;
            w_wr_idx  = w_tos_inc;
            if (w_full) begin
               w_ovf = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + (PTR_WIDTH+1)'(1);
            end
         end else if (i_ret) begin
            if (w_empty) begin
               w_unf = 1'b1;
            end else begin
               w_pop     = 1'b1;
               w_tos_nxt = w_tos_dec;
               w_cnt_nxt = r_cnt - (PTR_WIDTH+1)'(1);
            end
         end
      end
   end

`ifdef RISCV_RAS_CHECKPOINT_EN
   logic [PTR_WIDTH-1:0] r_ckpt_tos;
   logic [PTR_WIDTH:0]   r_ckpt_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ckpt_tos <= '0;
         r_ckpt_cnt <= '0;
      end else if (!i_flush && w_upd && i_ckpt_save) begin
         r_ckpt_tos <= w_tos_nxt;
         r_ckpt_cnt <= w_cnt_nxt;
      end
   end

   assign w_flush_tos = r_ckpt_tos;
   assign w_flush_cnt = r_ckpt_cnt;
`else
   assign w_flush_tos = '0;
   assign w_flush_cnt = '0;
`endif

   // Control and output registers; flush overrides any instruction in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tos      <= '0;
         r_cnt      <= '0;
         r_ret_pc   <= '0;
         r_ras_read <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else if (i_flush) begin
         r_tos      <= w_flush_tos;
         r_cnt      <= w_flush_cnt;
         r_ras_read <= 1'b0;
         r_ovf      <= 1'b0;
         r_unf      <= 1'b0;
      end else begin
         r_tos      <= w_tos_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ras_read <= w_pop;
         r_ovf      <= w_ovf;
         r_unf      <= w_unf;
         if (w_pop) begin
            r_ret_pc <= r_mem[r_tos];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (!i_flush && w_wr_en) begin
         r_mem[w_wr_idx] <= w_push_val;
      end
   end

   assign o_ras_read  = r_ras_read;
   assign o_ret_pc    = r_ret_pc;
   assign o_empty     = w_empty;
   assign o_full      = w_full;
   assign o_overflow  = r_ovf;
   assign o_underflow = r_unf;

endmodule
